// File: rtl/hyperspace_seq_pkg.sv
// rtl/hyperspace_seq_pkg.sv - shared types and defaults for the HyperSpace frame sequencer
package hyperspace_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  localparam int DEF_IN_LEN  = 2048;
  localparam int DEF_OUT_LEN = 1536;
  localparam int DEF_TIMEOUT = 4096;

endpackage

// File: rtl/hyperspace_beat_counter.sv
// rtl/hyperspace_beat_counter.sv - per-frame beat counter with last-beat compare
module hyperspace_beat_counter #(
  parameter int LEN_W = 16
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             clear,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  output logic             is_last
);

  logic [LEN_W-1:0] cnt;

  // clear wins so a frame boundary never carries a stray beat into the next frame
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + LEN_W'(1);
    end
  end

  assign is_last = (cnt == len - LEN_W'(1));

endmodule

// File: rtl/hyperspace_frame_sequencer.sv
// rtl/hyperspace_frame_sequencer.sv - frame-level sequencer between pad streams and the spectrometer core
import hyperspace_seq_pkg::*;

module hyperspace_frame_sequencer #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 16,
  parameter int LEN_W  = 16,
  parameter int TO_W   = 20,
  parameter int FCNT_W = 16
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic [LEN_W-1:0]  cfg_in_len,
  input  logic [LEN_W-1:0]  cfg_out_len,
  input  logic [TO_W-1:0]   cfg_timeout,
  input  logic              cfg_continuous,
  input  logic              start,
  input  logic              abort,
  input  logic              err_clear,
  input  logic              pad_in_valid,
  output logic              pad_in_ready,
  input  logic              pad_in_last,
  input  logic [IN_W-1:0]   pad_in_data,
  output logic              core_in_valid,
  input  logic              core_in_ready,
  output logic              core_in_last,
  output logic [IN_W-1:0]   core_in_data,
  input  logic              core_out_valid,
  output logic              core_out_ready,
  input  logic [OUT_W-1:0]  core_out_data,
  output logic              pad_out_valid,
  input  logic              pad_out_ready,
  output logic              pad_out_last,
  output logic [OUT_W-1:0]  pad_out_data,
  output logic              busy,
  output logic              done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err_cfg,
  output logic              err_early_last,
  output logic              err_timeout
);

  seq_state_t        state_q, state_d;
  logic [LEN_W-1:0]  in_len_q, out_len_q;
  logic [TO_W-1:0]   timeout_q, wdog_q, wdog_d;
  logic              cont_q, out_done_q, out_done_d;
  logic              in_is_last, out_is_last, in_open, out_open;
  logic              in_hs, out_hs, in_final, out_final, cfg_ok;
  logic              launch, rearm, complete, wdog_hit, cnt_clear, err_cfg_set, early_set;

  assign cfg_ok   = (cfg_in_len != '0) && (cfg_out_len != '0);
  assign in_open  = (state_q == LOAD);
  assign out_open = (state_q != IDLE) && !out_done_q;

  assign core_in_valid  = in_open & pad_in_valid;
  assign pad_in_ready   = in_open & core_in_ready;
  assign core_in_last   = in_open & in_is_last;
  assign core_in_data   = pad_in_data;
  assign pad_out_valid  = out_open & core_out_valid;
  assign core_out_ready = out_open & pad_out_ready;
  assign pad_out_last   = out_open & out_is_last;
  assign pad_out_data   = core_out_data;

  assign in_hs     = core_in_valid & core_in_ready;
  assign out_hs    = pad_out_valid & pad_out_ready;
  assign in_final  = in_hs & in_is_last;
  assign out_final = out_hs & out_is_last;
  assign early_set = in_hs & pad_in_last & !in_is_last;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    rearm       = 1'b0;
    complete    = 1'b0;
    wdog_hit    = 1'b0;
    err_cfg_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            launch  = 1'b1;
            state_d = LOAD;
          end else begin
            err_cfg_set = 1'b1;
          end
        end
      end
      LOAD: begin
        if (in_final) begin
          if (out_final) complete = 1'b1;
          else           state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (out_done_q || out_final) begin
          complete = 1'b1;
        end else if (timeout_q != '0 && wdog_q == timeout_q && !out_hs) begin
          wdog_hit = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a continuous re-arm samples live config; a zero length stops the run instead of hanging
    if (complete) begin
      if (cont_q && cfg_ok) begin
        rearm   = 1'b1;
        state_d = LOAD;
      end else begin
        state_d     = IDLE;
        err_cfg_set = cont_q;
      end
    end
    if (abort) begin
      state_d     = IDLE;
      launch      = 1'b0;
      rearm       = 1'b0;
      complete    = 1'b0;
      wdog_hit    = 1'b0;
      err_cfg_set = 1'b0;
    end
  end

  assign cnt_clear  = abort | launch | complete | wdog_hit;
  assign out_done_d = cnt_clear ? 1'b0 : (out_done_q | out_final);

  always_comb begin
    wdog_d = wdog_q;
    if (cnt_clear)               wdog_d = '0;
    else if (state_q == DRAIN)   wdog_d = out_hs ? '0 : wdog_q + TO_W'(1);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q        <= IDLE;
      in_len_q       <= '0;
      out_len_q      <= '0;
      timeout_q      <= '0;
      cont_q         <= 1'b0;
      out_done_q     <= 1'b0;
      wdog_q         <= '0;
      done           <= 1'b0;
      frame_cnt      <= '0;
      err_cfg        <= 1'b0;
      err_early_last <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_done_q <= out_done_d;
      wdog_q     <= wdog_d;
      done       <= complete;
      frame_cnt  <= frame_cnt + FCNT_W'(complete);
      if (launch || rearm) begin
        in_len_q  <= cfg_in_len;
        out_len_q <= cfg_out_len;
        timeout_q <= cfg_timeout;
        cont_q    <= cfg_continuous;
      end
      err_cfg        <= err_cfg_set | (err_cfg & !err_clear);
      err_early_last <= early_set | (err_early_last & !err_clear);
      err_timeout    <= wdog_hit | (err_timeout & !err_clear);
    end
  end

  hyperspace_beat_counter #(.LEN_W(LEN_W)) u_in_cnt (
    .clock   (clock),
    .resetb  (resetb),
    .clear   (cnt_clear),
    .inc     (in_hs),
    .len     (in_len_q),
    .is_last (in_is_last)
  );

  hyperspace_beat_counter #(.LEN_W(LEN_W)) u_out_cnt (
    .clock   (clock),
    .resetb  (resetb),
    .clear   (cnt_clear),
    .inc     (out_hs),
    .len     (out_len_q),
    .is_last (out_is_last)
  );

endmodule

// File: tb/tb_hyperspace_frame_sequencer.sv
// tb/tb_hyperspace_frame_sequencer.sv - scoreboard bench for the HyperSpace frame sequencer
module tb_hyperspace_frame_sequencer;
  import hyperspace_seq_pkg::*;

  localparam int IN_W = 8, OUT_W = 16, LEN_W = 16, TO_W = 20, FCNT_W = 16;
  localparam int HS_TMO = 300;

  logic              clock, resetb;
  logic [LEN_W-1:0]  cfg_in_len, cfg_out_len;
  logic [TO_W-1:0]   cfg_timeout;
  logic              cfg_continuous, start, abort, err_clear;
  logic              pad_in_valid, pad_in_ready, pad_in_last;
  logic [IN_W-1:0]   pad_in_data;
  logic              core_in_valid, core_in_ready, core_in_last;
  logic [IN_W-1:0]   core_in_data;
  logic              core_out_valid, core_out_ready;
  logic [OUT_W-1:0]  core_out_data;
  logic              pad_out_valid, pad_out_ready, pad_out_last;
  logic [OUT_W-1:0]  pad_out_data;
  logic              busy, done, err_cfg, err_early_last, err_timeout;
  logic [FCNT_W-1:0] frame_cnt;

  hyperspace_frame_sequencer dut (
    .clock(clock), .resetb(resetb),
    .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len), .cfg_timeout(cfg_timeout),
    .cfg_continuous(cfg_continuous), .start(start), .abort(abort), .err_clear(err_clear),
    .pad_in_valid(pad_in_valid), .pad_in_ready(pad_in_ready), .pad_in_last(pad_in_last),
    .pad_in_data(pad_in_data),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in_last(core_in_last),
    .core_in_data(core_in_data),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready), .core_out_data(core_out_data),
    .pad_out_valid(pad_out_valid), .pad_out_ready(pad_out_ready), .pad_out_last(pad_out_last),
    .pad_out_data(pad_out_data),
    .busy(busy), .done(done), .frame_cnt(frame_cnt),
    .err_cfg(err_cfg), .err_early_last(err_early_last), .err_timeout(err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  int done_seen = 0, idle_gaps = 0;
  bit rnd = 0, cont_win = 0;
  logic [IN_W:0]  exp_in[$];
  logic [OUT_W:0] exp_out[$];
  logic [IN_W:0]  ei;
  logic [OUT_W:0] eo;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail_note(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event not seen within bound", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // scoreboard monitor: pops on every accepted beat
  always @(negedge clock) begin
    if (resetb) begin
      if (core_in_valid && core_in_ready) begin
        if (exp_in.size() == 0) begin
          fail_note("core_in_unexpected_beat");
        end else begin
          ei = exp_in.pop_front();
          check("core_in_data", core_in_data, ei[IN_W-1:0]);
          check("core_in_last", core_in_last, ei[IN_W]);
        end
      end
      if (pad_out_valid && pad_out_ready) begin
        if (exp_out.size() == 0) begin
          fail_note("pad_out_unexpected_word");
        end else begin
          eo = exp_out.pop_front();
          check("pad_out_data", pad_out_data, eo[OUT_W-1:0]);
          check("pad_out_last", pad_out_last, eo[OUT_W]);
        end
      end
      if (done) done_seen++;
      if (cont_win && !busy) idle_gaps++;
    end
  end

  initial begin
    core_in_ready = 1'b1;
    pad_out_ready = 1'b1;
    forever begin
      tick();
      core_in_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pad_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_run(input int il, input int ol, input int to, input bit cont);
    cfg_in_len     = LEN_W'(il);
    cfg_out_len    = LEN_W'(ol);
    cfg_timeout    = TO_W'(to);
    cfg_continuous = cont;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_in(input int len, input int nb, input int base, input int early, input bit gaps);
    bit hs;
    int t;
    for (int k = 0; k < nb; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        pad_in_valid = 1'b0;
        tick();
      end
      pad_in_data  = IN_W'(base + k);
      pad_in_last  = (k == early) || (k == len - 1);
      pad_in_valid = 1'b1;
      exp_in.push_back({(k == len - 1), pad_in_data});
      hs = 0;
      t  = 0;
      while (!hs && t < HS_TMO) begin
        @(negedge clock);
        hs = pad_in_ready;
        tick();
        t++;
      end
      if (!hs) fail_note("pad_in_handshake");
    end
    pad_in_valid = 1'b0;
    pad_in_last  = 1'b0;
  endtask

  task automatic send_out(input int len, input int nb, input int base, input bit gaps);
    bit hs;
    int t;
    for (int k = 0; k < nb; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        core_out_valid = 1'b0;
        tick();
      end
      core_out_data  = OUT_W'(base + k);
      core_out_valid = 1'b1;
      exp_out.push_back({(k == len - 1), core_out_data});
      hs = 0;
      t  = 0;
      while (!hs && t < HS_TMO) begin
        @(negedge clock);
        hs = core_out_ready;
        tick();
        t++;
      end
      if (!hs) fail_note("core_out_handshake");
    end
    core_out_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit ok;
    ok = 0;
    for (int t = 0; t < bound && !ok; t++) begin
      @(negedge clock);
      if (done) ok = 1;
    end
    if (!ok) fail_note("done_pulse");
  endtask

  initial begin
    resetb = 1'b0;
    cfg_in_len = '0; cfg_out_len = '0; cfg_timeout = '0; cfg_continuous = 1'b0;
    start = 1'b0; abort = 1'b0; err_clear = 1'b0;
    pad_in_valid = 1'b0; pad_in_last = 1'b0; pad_in_data = '0;
    core_out_valid = 1'b0; core_out_data = '0;
    repeat (3) @(posedge clock);
    #1 resetb = 1'b1;
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_cfg", err_cfg, 0);
    check("rst_err_early", err_early_last, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_pad_in_ready", pad_in_ready, 0);
    check("rst_core_out_ready", core_out_ready, 0);

    // full-size single shot
    tick();
    start_run(DEF_IN_LEN, DEF_OUT_LEN, 0, 0);
    fork
      send_in(DEF_IN_LEN, DEF_IN_LEN, 0, -1, 0);
      send_out(DEF_OUT_LEN, DEF_OUT_LEN, 16'h1000, 0);
    join
    wait_done(20);
    check("single_busy_at_done", busy, 0);
    check("single_frame_cnt", frame_cnt, 1);

    // random stalls on both sides
    rnd = 1;
    start_run(40, 30, 0, 0);
    fork
      send_in(40, 40, 8'h55, -1, 1);
      send_out(30, 30, 16'hA000, 1);
    join
    wait_done(50);
    rnd = 0;
    check("stall_frame_cnt", frame_cnt, 2);
    check("stall_busy", busy, 0);

    // continuous, three frames; frame-1 input is delayed so word 13 is held off
    start_run(16, 12, 0, 1);
    cont_win = 1;
    fork
      begin
        repeat (20) tick();
        for (int f = 0; f < 3; f++) send_in(16, 16, f * 16, -1, 0);
      end
      begin
        for (int f = 0; f < 3; f++) send_out(12, 12, 16'h2000 + f * 12, 0);
      end
      begin
        repeat (16) @(negedge clock);
        check("hold_core_out_ready", core_out_ready, 0);
        check("hold_pad_out_valid", pad_out_valid, 0);
      end
      begin
        for (int f = 0; f < 3; f++) wait_done(400);
      end
    join
    cont_win = 0;
    check("cont_frame_cnt", frame_cnt, 5);
    check("cont_idle_gaps", idle_gaps, 0);
    cfg_continuous = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clock);
    check("cont_abort_busy", busy, 0);

    // early pad_in_last
    tick();
    start_run(16, 12, 0, 0);
    fork
      send_in(16, 16, 8'h80, 10, 0);
      send_out(12, 12, 16'h3000, 0);
    join
    wait_done(20);
    check("early_err_set", err_early_last, 1);
    check("early_frame_cnt", frame_cnt, 6);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    @(negedge clock);
    check("early_err_cleared", err_early_last, 0);

    // drain watchdog
    tick();
    start_run(16, 12, 100, 0);
    fork
      send_in(16, 16, 8'h40, -1, 0);
      send_out(12, 5, 16'h4000, 0);
    join
    repeat (50) @(negedge clock);
    check("wdog_not_early", err_timeout, 0);
    check("wdog_busy_waiting", busy, 1);
    for (int t = 0; t < 200 && !err_timeout; t++) @(negedge clock);
    check("wdog_err_timeout", err_timeout, 1);
    check("wdog_idle", busy, 0);
    check("wdog_frame_cnt", frame_cnt, 6);

    // abort mid-LOAD, then a zero-length start
    tick();
    start_run(16, 12, 0, 0);
    send_in(16, 7, 8'h10, -1, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_pad_in_ready", pad_in_ready, 0);
    check("abort_frame_cnt", frame_cnt, 6);
    tick();
    start_run(0, 12, 0, 0);
    @(negedge clock);
    check("zero_len_err_cfg", err_cfg, 1);
    check("zero_len_busy", busy, 0);

    repeat (5) tick();
    check("total_done_pulses", done_seen, 6);
    check("exp_in_drained", exp_in.size(), 0);
    check("exp_out_drained", exp_out.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hyperspace_frame_sequencer.md
Name: hyperspace_frame_sequencer

Overview:
- Frame-level controller between the pad-side AXI4-Stream ports (8-bit in, 16-bit out) and the HyperSpace spectrometer core.
- Admits exactly one configured-length input frame per run and generates core in_last.
- Forwards the core's output frame to the pads and generates out_last at the configured output length.
- Supports single-shot or continuous runs, abort, and a drain watchdog; configured from user-project registers.

Parameters:
- IN_W, 8, input sample width
- OUT_W, 16, output word width
- LEN_W, 16, width of frame-length counters and config fields
- TO_W, 20, drain-watchdog counter width
- FCNT_W, 16, completed-frame counter width

Ports:
- clock  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- cfg_in_len  in  LEN_W  input samples per frame (e.g. 2048)
- cfg_out_len  in  LEN_W  output words per frame (e.g. 1536)
- cfg_timeout  in  TO_W  max idle cycles in DRAIN before error
- cfg_continuous  in  1  re-arm automatically after each frame
- start  in  1  one-cycle run request
- abort  in  1  one-cycle abort request
- err_clear  in  1  clears sticky error flags
- pad_in_valid / pad_in_ready / pad_in_last  in / out / in  1  pad input handshake
- pad_in_data  in  IN_W  pad input data
- core_in_valid / core_in_ready / core_in_last  out / in / out  1  core input handshake
- core_in_data  out  IN_W  core input data
- core_out_valid / core_out_ready  in / out  1  core output handshake
- core_out_data  in  OUT_W  core output data
- pad_out_valid / pad_out_ready / pad_out_last  out / in / out  1  pad output handshake
- pad_out_data  out  OUT_W  pad output data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a frame completes
- frame_cnt  out  FCNT_W  frames completed since reset (wraps)
- err_cfg, err_early_last, err_timeout  out  1  sticky error flags

Behaviour:
- Reset: state IDLE; counters, frame_cnt, shadow config, done and all error flags 0.
  - All valid/ready/last outputs are 0 in IDLE; data outputs pass through combinationally, values don't-care while valid=0.
- States: IDLE, LOAD, DRAIN. Sequencing is registered; data/handshake paths are combinational passthrough with zero latency.
- IDLE:
  - start with both lengths nonzero: latch cfg_* into a shadow, clear in_cnt/out_cnt/out_done/wdog, go to LOAD.
  - start with either length zero: set err_cfg, stay in IDLE.
- LOAD, input path open:
  - core_in_valid=pad_in_valid, pad_in_ready=core_in_ready, core_in_data=pad_in_data.
  - core_in_last=(in_cnt==in_len-1).
  - in_cnt increments on each handshake; the last-beat handshake goes to DRAIN.
  - pad_in_last asserted with in_cnt<in_len-1: set err_early_last, forward the beat, keep counting. pad_in_last missing on the final beat is ignored.
- Output path, open in LOAD and DRAIN while out_done=0:
  - pad_out_valid=core_out_valid, core_out_ready=pad_out_ready, pad_out_data=core_out_data.
  - pad_out_last=(out_cnt==out_len-1).
  - Handshake increments out_cnt; the last beat sets out_done.
  - Once out_done=1, core_out_ready=0 and pad_out_valid=0 (excess core words are back-pressured).
- DRAIN, input path closed (core_in_valid=0, pad_in_ready=0):
  - When out_done=1 (or the final out beat in this cycle): done pulse, frame_cnt+1.
  - Then, if continuous: re-latch config, clear counters, go to LOAD. Else go to IDLE.
- Simultaneous final input beat and final output beat in LOAD: the frame completes that cycle; DRAIN is entered for zero cycles (next state per continuous rule), done pulses once.
- Watchdog:
  - wdog counts DRAIN cycles without an output handshake; it resets on any output handshake.
  - wdog==timeout: set err_timeout, go to IDLE, no done, frame_cnt unchanged.
  - timeout==0 disables the watchdog.
- abort, any state: next state IDLE, counters cleared, no done. Abort has priority over start and over frame completion in the same cycle.
- start outside IDLE is ignored. Config input changes mid-frame are ignored (the shadow is used).
- err_clear clears all sticky flags; a set event in the same cycle wins.

Decomposition:
- Package hyperspace_seq_pkg:
  - state enum (IDLE/LOAD/DRAIN)
  - default frame lengths (2048/1536) and default timeout constant
- Sub-module hyperspace_beat_counter (LEN_W counter with clear, increment-on-handshake, is_last compare), instantiated twice (input and output).

Test Plan:
- Single shot, in_len=2048, out_len=1536, ready always high → core_in_last on beat 2048 only, pad_out_last on word 1536, one done, frame_cnt=1, busy falls the cycle after.
- Random pad_out_ready (50%) and core_in_ready stalls → no beat lost or duplicated; counts exact; data order preserved.
- Continuous mode, 3 frames, in_len=16, out_len=12 → 3 done pulses, frame_cnt=3, no idle cycle between frames; a 13th core word is held off (core_out_ready=0).
- pad_in_last at beat 10 with in_len=16 → err_early_last=1, 16 beats still forwarded; err_clear → 0.
- cfg_timeout=100, core emits only 5 of 12 words → err_timeout after 100 idle DRAIN cycles, IDLE, frame_cnt unchanged.
- abort mid-LOAD at beat 7 → IDLE next cycle, no done; a new start with in_len=0 → err_cfg=1, state stays IDLE.
